// File: rtl/gdp_arbiter.sv
// -----------------------------------------------------------------------------
// gdp_arbiter
//
// Shares a single GDP instance (bit-count datapath plus control unit) between
// two independent requesters. A round-robin arbiter picks a winner, latches
// its 8-bit operand onto the GDP input, pulses GDP start, waits for GDP done
// (with a timeout), returns the captured run sum to the winner, then restarts
// the GDP so it is clean for the next job.
//
// Handshakes:
//   Request side: req_k is a level. While req_k is high n_k must be stable.
//   A one-cycle grant_k pulse says the operand has been captured and req_k
//   may be dropped. Requester k is only eligible while it has no pending
//   (unacknowledged) response.
//   Response side: rsp_valid_k rises with rsp_sum_k and both hold until
//   rsp_ack_k is sampled high while rsp_valid_k is high; rsp_valid_k is low
//   the following cycle. rsp_ack_k sampled while rsp_valid_k is low has no
//   effect.
//
// Ports:
//   clock, restart           clock (rising edge), synchronous active-high reset
//   req0/n0/grant0           requester 0 job request, operand, grant pulse
//   rsp_valid0/rsp_sum0/
//   rsp_ack0                 requester 0 response channel
//   req1 ... rsp_ack1        same for requester 1
//   gdp_n_in, gdp_start,
//   gdp_restart              drive the GDP operand, start and restart
//   gdp_done, gdp_sum        GDP completion flag and run sum
//   busy                     high whenever the sequencer is not IDLE
//   timeout_err              sticky: some job was abandoned on timeout
//   dbg_state                current sequencer state (debug observation)
// -----------------------------------------------------------------------------
module gdp_arbiter #(
    parameter int TIMEOUT = 64   // max cycles in WAIT, legal range 2..255
) (
    input  logic       clock,
    input  logic       restart,

    input  logic       req0,
    input  logic [7:0] n0,
    output logic       grant0,
    output logic       rsp_valid0,
    output logic [7:0] rsp_sum0,
    input  logic       rsp_ack0,

    input  logic       req1,
    input  logic [7:0] n1,
    output logic       grant1,
    output logic       rsp_valid1,
    output logic [7:0] rsp_sum1,
    input  logic       rsp_ack1,

    output logic [7:0] gdp_n_in,
    output logic       gdp_start,
    output logic       gdp_restart,
    input  logic       gdp_done,
    input  logic [7:0] gdp_sum,

    output logic       busy,
    output logic       timeout_err,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_WAIT    = 3'd2,
        S_RECOVER = 3'd3,
        S_SETTLE  = 3'd4
    } state_e;

    // Last counter value allowed in WAIT before the job is abandoned.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_e     state_q,      state_d;
    logic       last_grant_q, last_grant_d;   // requester granted most recently
    logic       owner_q,      owner_d;        // requester owning the current job
    logic [7:0] cnt_q,        cnt_d;          // cycles spent in WAIT
    logic       grant0_q,     grant0_d;
    logic       grant1_q,     grant1_d;
    logic       rsp_valid0_q, rsp_valid0_d;
    logic       rsp_valid1_q, rsp_valid1_d;
    logic [7:0] rsp_sum0_q,   rsp_sum0_d;
    logic [7:0] rsp_sum1_q,   rsp_sum1_d;
    logic [7:0] n_in_q,       n_in_d;
    logic       start_q,      start_d;
    logic       terr_q,       terr_d;

    logic       elig0;
    logic       elig1;
    logic       pick1;

    // A requester with an unacknowledged result cannot start another job.
    assign elig0 = req0 & ~rsp_valid0_q;
    assign elig1 = req1 & ~rsp_valid1_q;

    // Requester 1 wins when it is the only eligible one, or when both are
    // eligible and requester 0 was served last.
    assign pick1 = elig1 & (~elig0 | ~last_grant_q);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        grant0_d     = 1'b0;
        grant1_d     = 1'b0;
        rsp_valid0_d = rsp_valid0_q;
        rsp_valid1_d = rsp_valid1_q;
        rsp_sum0_d   = rsp_sum0_q;
        rsp_sum1_d   = rsp_sum1_q;
        n_in_d       = n_in_q;
        start_d      = 1'b0;
        terr_d       = terr_q;

        // Response consumption. A set from WAIT below can never hit the same
        // requester in the same cycle: the owner had no pending response.
        if (rsp_valid0_q && rsp_ack0) begin
            rsp_valid0_d = 1'b0;
        end
        if (rsp_valid1_q && rsp_ack1) begin
            rsp_valid1_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (elig0 || elig1) begin
                    if (pick1) begin
                        n_in_d       = n1;
                        owner_d      = 1'b1;
                        last_grant_d = 1'b1;
                        grant1_d     = 1'b1;
                    end else begin
                        n_in_d       = n0;
                        owner_d      = 1'b0;
                        last_grant_d = 1'b0;
                        grant0_d     = 1'b1;
                    end
                    state_d = S_LAUNCH;
                end
            end

            S_LAUNCH: begin
                start_d = 1'b1;
                cnt_d   = 8'd0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // done wins over a timeout landing in the same cycle.
                if (gdp_done) begin
                    if (owner_q) begin
                        rsp_sum1_d   = gdp_sum;
                        rsp_valid1_d = 1'b1;
                    end else begin
                        rsp_sum0_d   = gdp_sum;
                        rsp_valid0_d = 1'b1;
                    end
                    state_d = S_RECOVER;
                end else if (cnt_q == TO_LAST) begin
                    if (owner_q) begin
                        rsp_sum1_d   = 8'hFF;
                        rsp_valid1_d = 1'b1;
                    end else begin
                        rsp_sum0_d   = 8'hFF;
                        rsp_valid0_d = 1'b1;
                    end
                    terr_d  = 1'b1;
                    state_d = S_RECOVER;
                end
            end

            S_RECOVER: begin
                // gdp_restart is driven combinationally from this state.
                state_d = S_SETTLE;
            end

            S_SETTLE: begin
                // The GDP holds done until its restart takes effect; do not
                // reopen arbitration while a stale done is still visible.
                if (!gdp_done) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (restart) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= 8'd0;
            grant0_q     <= 1'b0;
            grant1_q     <= 1'b0;
            rsp_valid0_q <= 1'b0;
            rsp_valid1_q <= 1'b0;
            rsp_sum0_q   <= 8'd0;
            rsp_sum1_q   <= 8'd0;
            n_in_q       <= 8'd0;
            start_q      <= 1'b0;
            terr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            grant0_q     <= grant0_d;
            grant1_q     <= grant1_d;
            rsp_valid0_q <= rsp_valid0_d;
            rsp_valid1_q <= rsp_valid1_d;
            rsp_sum0_q   <= rsp_sum0_d;
            rsp_sum1_q   <= rsp_sum1_d;
            n_in_q       <= n_in_d;
            start_q      <= start_d;
            terr_q       <= terr_d;
        end
    end

    assign grant0      = grant0_q;
    assign grant1      = grant1_q;
    assign rsp_valid0  = rsp_valid0_q;
    assign rsp_valid1  = rsp_valid1_q;
    assign rsp_sum0    = rsp_sum0_q;
    assign rsp_sum1    = rsp_sum1_q;
    assign gdp_n_in    = n_in_q;
    assign gdp_start   = start_q;
    // The GDP is reset together with this block as well as after every job.
    assign gdp_restart = restart | (state_q == S_RECOVER);
    assign busy        = (state_q != S_IDLE);
    assign timeout_err = terr_q;
    assign dbg_state   = state_q;

endmodule
